// File: rtl/seq1101_detect_counter.sv
// Moore detector for the overlapping serial pattern 1101, with a saturating
// tally of detections and a saturation flag.
module seq1101_detect_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic             det,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // State and output registers; clr wins over everything else.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S0;
      det_q   <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state logic; with en low the FSM holds and din is ignored.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        S0:      state_d = din ? S1 : S0;
        S1:      state_d = din ? S2 : S0;
        S2:      state_d = din ? S2 : S3;
        S3:      state_d = din ? S4 : S0;
        S4:      state_d = din ? S2 : S0;
        default: state_d = S0;
      endcase
    end
  end

  // Output logic: det tracks S4, count bumps only on entry into S4.
  always_comb begin
    det_d   = (state_d == S4);
    count_d = count_q;
    if ((state_d == S4) && (state_q != S4) && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
    sat_d = (count_d == CNT_MAX);
  end

  assign det   = det_q;
  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_seq1101_detect_counter.sv
// Directed bench for seq1101_detect_counter; a CNT_W=4 and a CNT_W=2 instance
// share the same stimulus so saturation can be exercised quickly.
module tb_seq1101_detect_counter;

  logic       clk;
  logic       clr;
  logic       en;
  logic       din;
  logic       det4, det2;
  logic [3:0] count4;
  logic [1:0] count2;
  logic       sat4, sat2;

  int n_cmp;
  int n_err;

  seq1101_detect_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .clr(clr), .en(en), .din(din),
    .det(det4), .count(count4), .sat(sat4)
  );

  seq1101_detect_counter #(.CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .en(en), .din(din),
    .det(det2), .count(count2), .sat(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one rising edge, then settle just after it.
  task automatic step(input logic c, input logic e, input logic d);
    clr = c;
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask

  // One enabled bit; both instances must agree on det.
  task automatic feed(input string tag, input logic d, input logic exp_det);
    step(1'b1, 1'b1, d);
    check_eq({tag, ".det4"}, int'(det4), int'(exp_det));
    check_eq({tag, ".det2"}, int'(det2), int'(exp_det));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr   = 1'b0;
    en    = 1'b1;
    din   = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst.det",   int'(det4),   0);
    check_eq("rst.count", int'(count4), 0);
    check_eq("rst.sat",   int'(sat4),   0);

    // Basic match
    feed("t1.b1", 1'b1, 1'b0);
    feed("t1.b2", 1'b1, 1'b0);
    feed("t1.b3", 1'b0, 1'b0);
    feed("t1.b4", 1'b1, 1'b1);
    check_eq("t1.count", int'(count4), 1);
    check_eq("t1.sat",   int'(sat4),   0);
    feed("t1.b5", 1'b0, 1'b0);
    check_eq("t1.count_hold", int'(count4), 1);

    // Overlap 1101101
    do_reset();
    feed("t2.b1", 1'b1, 1'b0);
    feed("t2.b2", 1'b1, 1'b0);
    feed("t2.b3", 1'b0, 1'b0);
    feed("t2.b4", 1'b1, 1'b1);
    feed("t2.b5", 1'b1, 1'b0);
    feed("t2.b6", 1'b0, 1'b0);
    feed("t2.b7", 1'b1, 1'b1);
    check_eq("t2.count", int'(count4), 2);

    // Long run of ones: 111101
    do_reset();
    feed("t2b.b1", 1'b1, 1'b0);
    feed("t2b.b2", 1'b1, 1'b0);
    feed("t2b.b3", 1'b1, 1'b0);
    feed("t2b.b4", 1'b1, 1'b0);
    feed("t2b.b5", 1'b0, 1'b0);
    feed("t2b.b6", 1'b1, 1'b1);
    check_eq("t2b.count", int'(count4), 1);

    // Near-miss 101011001; ends in S1, so 101 then completes a match
    do_reset();
    feed("t3.b1", 1'b1, 1'b0);
    feed("t3.b2", 1'b0, 1'b0);
    feed("t3.b3", 1'b1, 1'b0);
    feed("t3.b4", 1'b0, 1'b0);
    feed("t3.b5", 1'b1, 1'b0);
    feed("t3.b6", 1'b1, 1'b0);
    feed("t3.b7", 1'b0, 1'b0);
    feed("t3.b8", 1'b0, 1'b0);
    feed("t3.b9", 1'b1, 1'b0);
    check_eq("t3.count", int'(count4), 0);
    feed("t3.c1", 1'b1, 1'b0);
    feed("t3.c2", 1'b0, 1'b0);
    feed("t3.c3", 1'b1, 1'b1);
    check_eq("t3.count_after", int'(count4), 1);

    // Enable hold in S3, then in S4
    do_reset();
    feed("t4.b1", 1'b1, 1'b0);
    feed("t4.b2", 1'b1, 1'b0);
    feed("t4.b3", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check_eq("t4.hold_det", int'(det4), 0);
    end
    feed("t4.b4", 1'b1, 1'b1);
    check_eq("t4.count", int'(count4), 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check_eq("t4.s4_det",   int'(det4),   1);
      check_eq("t4.s4_count", int'(count4), 1);
    end
    feed("t4.release", 1'b0, 1'b0);
    check_eq("t4.count_end", int'(count4), 1);

    // Saturation: five back-to-back 1101 patterns
    do_reset();
    for (int p = 0; p < 5; p++) begin
      feed("t5.b1", 1'b1, 1'b0);
      feed("t5.b2", 1'b1, 1'b0);
      feed("t5.b3", 1'b0, 1'b0);
      feed("t5.b4", 1'b1, 1'b1);
      check_eq("t5.count2", int'(count2), (p < 3) ? p + 1 : 3);
      check_eq("t5.sat2",   int'(sat2),   (p >= 2) ? 1 : 0);
      check_eq("t5.count4", int'(count4), p + 1);
    end
    check_eq("t5.sat4", int'(sat4), 0);
    // clr beats en=0 and clears saturation
    step(1'b0, 1'b0, 1'b1);
    check_eq("t5.clr_count2", int'(count2), 0);
    check_eq("t5.clr_sat2",   int'(sat2),   0);
    check_eq("t5.clr_det2",   int'(det2),   0);

    // Reset mid-sequence discards the partial 110
    do_reset();
    feed("t6.b1", 1'b1, 1'b0);
    feed("t6.b2", 1'b1, 1'b0);
    feed("t6.b3", 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check_eq("t6.rst_det",   int'(det4),   0);
    check_eq("t6.rst_count", int'(count4), 0);
    check_eq("t6.rst_sat",   int'(sat4),   0);
    feed("t6.c1", 1'b1, 1'b0);
    feed("t6.c2", 1'b1, 1'b0);
    feed("t6.c3", 1'b0, 1'b0);
    feed("t6.c4", 1'b1, 1'b1);
    check_eq("t6.count", int'(count4), 1);

    // clr on the completing edge
    do_reset();
    feed("t6b.b1", 1'b1, 1'b0);
    feed("t6b.b2", 1'b1, 1'b0);
    feed("t6b.b3", 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check_eq("t6b.det",   int'(det4),   0);
    check_eq("t6b.count", int'(count4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
